// File: rtl/run_seq_gen.sv
// Serial run-length stimulus generator: turns (bit, length) commands into a bit
// stream on x, with the expected three-in-a-row detector output alongside each bit.
module run_seq_gen #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [LEN_W-1:0] in_len,
  output logic             x,
  output logic             x_valid,
  output logic             y_exp,
  output logic             busy
);

  localparam int unsigned STREAK_W = 2;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(3);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  logic                cur_bit_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [STREAK_W-1:0] streak_q;
  logic                x_q;
  logic                x_valid_q;
  logic                y_exp_q;

  logic                accept_d;
  logic                load_d;
  logic                emit_bit_d;
  logic [STREAK_W-1:0] streak_d;
  logic [LEN_W-1:0]    remaining_d;

  // Ready while idle, or on the last bit of a run so the next command follows without a bubble.
  assign in_ready = !reset && ((state_q == IDLE) ||
                               ((state_q == SEND) && (remaining_q == LEN_W'(1))));

  // Streak of the bit about to be driven; continues only across contiguous equal valid bits.
  always_comb begin
    accept_d    = in_valid && in_ready;
    load_d      = accept_d && (in_len != '0);
    emit_bit_d  = load_d ? in_bit : cur_bit_q;
    remaining_d = remaining_q - LEN_W'(1);
    streak_d    = STREAK_W'(1);
    if (x_valid_q && (x_q == emit_bit_d)) begin
      streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_bit_q   <= 1'b0;
      remaining_q <= '0;
      streak_q    <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      y_exp_q     <= 1'b0;
    end else if (load_d) begin
      state_q     <= SEND;
      cur_bit_q   <= in_bit;
      remaining_q <= in_len;
      streak_q    <= streak_d;
      x_q         <= in_bit;
      x_valid_q   <= 1'b1;
      y_exp_q     <= (streak_d == STREAK_MAX);
    end else if (state_q == SEND) begin
      remaining_q <= remaining_d;
      if (remaining_q <= LEN_W'(1)) begin
        // Last bit done (a zero-length command taken here just ends the run).
        state_q   <= IDLE;
        streak_q  <= '0;
        x_valid_q <= 1'b0;
        y_exp_q   <= 1'b0;
      end else begin
        streak_q  <= streak_d;
        x_q       <= cur_bit_q;
        x_valid_q <= 1'b1;
        y_exp_q   <= (streak_d == STREAK_MAX);
      end
    end else begin
      streak_q  <= '0;
      x_valid_q <= 1'b0;
      y_exp_q   <= 1'b0;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign y_exp   = y_exp_q;
  assign busy    = (state_q == SEND);

endmodule

// File: tb/tb_run_seq_gen.sv
// Directed bench for run_seq_gen: per-cycle vector table plus hand-written
// sequences for reset, maximum run length and asynchronous mid-run reset.
module tb_run_seq_gen;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [3:0] in_len;
  logic       x;
  logic       x_valid;
  logic       y_exp;
  logic       busy;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  run_seq_gen #(.LEN_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .in_len   (in_len),
    .x        (x),
    .x_valid  (x_valid),
    .y_exp    (y_exp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock: inputs for the coming edge, outputs expected after it.
  typedef struct packed {
    logic       v;
    logic       b;
    logic [3:0] len;
    logic [4:0] exp; // {x, x_valid, y_exp, in_ready, busy}
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [4:0] outs();
    return {x, x_valid, y_exp, in_ready, busy};
  endfunction

  initial begin
    int xv_cnt;
    int y_cnt;
    int one_cnt;
    int rdy_cnt;
    int stray_cnt;

    // Command (0,3) from idle
    tbl[0]  = '{1'b1, 1'b0, 4'd3, 5'b01001};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 5'b01001};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 5'b01111};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 5'b00010};
    // (1,2) then back-to-back (1,2)
    tbl[4]  = '{1'b1, 1'b1, 4'd2, 5'b11001};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 5'b11011};
    tbl[6]  = '{1'b1, 1'b1, 4'd2, 5'b11101};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 5'b11111};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 5'b10010};
    // Mixed: (0,1),(1,1),(0,3),(1,3) back-to-back
    tbl[9]  = '{1'b1, 1'b0, 4'd1, 5'b01011};
    tbl[10] = '{1'b1, 1'b1, 4'd1, 5'b11011};
    tbl[11] = '{1'b1, 1'b0, 4'd3, 5'b01001};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 5'b01001};
    tbl[13] = '{1'b0, 1'b0, 4'd0, 5'b01111};
    tbl[14] = '{1'b1, 1'b1, 4'd3, 5'b11001};
    tbl[15] = '{1'b0, 1'b0, 4'd0, 5'b11001};
    tbl[16] = '{1'b0, 1'b0, 4'd0, 5'b11111};
    tbl[17] = '{1'b0, 1'b0, 4'd0, 5'b10010};
    // (1,2), one-cycle gap, (1,2): gap clears the streak
    tbl[18] = '{1'b1, 1'b1, 4'd2, 5'b11001};
    tbl[19] = '{1'b0, 1'b0, 4'd0, 5'b11011};
    tbl[20] = '{1'b0, 1'b0, 4'd0, 5'b10010};
    tbl[21] = '{1'b1, 1'b1, 4'd2, 5'b11001};
    tbl[22] = '{1'b0, 1'b0, 4'd0, 5'b11011};
    tbl[23] = '{1'b0, 1'b0, 4'd0, 5'b10010};
    // (0,0) from idle: consumed, no pulse, x holds
    tbl[24] = '{1'b1, 1'b0, 4'd0, 5'b10010};
    tbl[25] = '{1'b0, 1'b0, 4'd0, 5'b10010};
    // (0,2); a zero-length command offered early is ignored, taken on the last bit
    tbl[26] = '{1'b1, 1'b0, 4'd2, 5'b01001};
    tbl[27] = '{1'b1, 1'b1, 4'd0, 5'b01011};
    tbl[28] = '{1'b1, 1'b1, 4'd0, 5'b00010};

    // Reset held with a command pending
    reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_len = 4'd5;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'(5'b00000));
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("release_ready_busy", 32'({in_ready, busy}), 32'(2'b10));
    @(negedge clk);
    chk("idle_after_release", 32'(outs()), 32'(5'b00010));

    for (int i = 0; i < NVEC; i++) begin
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      in_len   = tbl[i].len;
      @(posedge clk);
      @(negedge clk);
      if (outs() !== tbl[i].exp)
        $display("FAIL row%0d {x,x_valid,y_exp,in_ready,busy}: got %b, want %b", i, outs(), tbl[i].exp);
      total_cnt++;
      if (outs() === tbl[i].exp) pass_cnt++;
    end
    in_valid = 1'b0;

    // Maximum length run: 15 ones, y_exp from the third bit on, ready only on the last
    in_valid = 1'b1; in_bit = 1'b1; in_len = 4'hF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    xv_cnt = 0; y_cnt = 0; one_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (x_valid) begin
        xv_cnt++;
        if (x) one_cnt++;
        if (y_exp) y_cnt++;
        if (in_ready) rdy_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("maxlen_bits", 32'(xv_cnt), 32'd15);
    chk("maxlen_ones", 32'(one_cnt), 32'd15);
    chk("maxlen_yexp", 32'(y_cnt), 32'd13);
    chk("maxlen_ready_last", 32'(rdy_cnt), 32'd1);
    chk("maxlen_end", 32'(outs()), 32'(5'b10010));

    // Asynchronous reset in the middle of a (1,15) run, at bit 5
    in_valid = 1'b1; in_bit = 1'b1; in_len = 4'hF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("midrun_before_reset", 32'(outs()), 32'(5'b11101));
    reset = 1'b1;
    #1;
    chk("midrun_async_reset", 32'(outs()), 32'(5'b00000));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (x_valid || busy) stray_cnt++;
    end
    chk("no_residual_bits", 32'(stray_cnt), 32'd0);
    chk("post_reset_idle", 32'(outs()), 32'(5'b00010));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
